// File: rtl/prog_loader.sv
// prog_loader: streams a host image into memory, optionally verifies a read-back checksum, then releases the core.
// Optional read-back verify is enabled by defining LOADER_VERIFY_EN.
module prog_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              bus_own,
  output logic              core_reset_n,
  output logic              trigger_program,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RELEASE, DONE, ERROR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_r, len_r, count, count_nx;
  logic trig_r, hs, go, last;
  assign go = start && (state == IDLE || state == DONE || state == ERROR);
  assign last = count == len_r;
  assign s_ready = state == LOAD && count < len_r;
  assign hs = s_valid && s_ready;
  assign mem_we = hs;
  assign mem_addr = base_r + count;
  assign mem_din = hs ? s_data : '0;
  assign bus_own = state == LOAD || state == VERIFY;
  assign core_reset_n = state == RELEASE || state == DONE;
  assign busy = state == LOAD || state == VERIFY || state == RELEASE;
  assign done = state == DONE;
  assign trigger_program = trig_r;
`ifdef LOADER_VERIFY_EN
  logic [DATA_W-1:0] sum, rsum, rsum_nx;
  // read data lags its address by one cycle, so count==0 has nothing to accumulate yet
  assign rsum_nx = rsum + ((state == VERIFY && count != '0) ? mem_dout : '0);
  assign err = state == ERROR;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sum  <= '0;
      rsum <= '0;
    end else begin
      sum  <= go ? '0 : (hs ? sum + s_data : sum);
      rsum <= go ? '0 : rsum_nx;
    end
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (go) begin
      state_nx = LOAD;
      count_nx = '0;
    end else if (state == LOAD) begin
      count_nx = last ? '0 : count + ADDR_W'(hs);
`ifdef LOADER_VERIFY_EN
      state_nx = last ? VERIFY : LOAD;
`else
      state_nx = last ? RELEASE : LOAD;
`endif
`ifdef LOADER_VERIFY_EN
    end else if (state == VERIFY) begin
      count_nx = count + 1'b1;
      state_nx = !last ? VERIFY : (rsum_nx == sum ? RELEASE : ERROR);
`endif
    end else if (state == RELEASE) begin
      state_nx = DONE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      base_r <= '0;
      len_r  <= '0;
      trig_r <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      base_r <= go ? base_addr : base_r;
      len_r  <= go ? length : len_r;
      trig_r <= state == RELEASE;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scoreboard bench; expected writes are queued at stimulus time and popped by a monitor.
module tb_prog_loader;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, s_valid = 1'b0, corrupt = 1'b0;
  logic [15:0] base_addr = '0, length = '0;
  logic [7:0] s_data = '0, mem_dout = '0;
  logic s_ready, mem_we, bus_own, core_reset_n, trigger_program, busy, done, err;
  logic [15:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem [0:65535];
  logic [7:0] img [0:15];
  logic [15:0] sb_addr [$];
  logic [7:0] sb_data [$];
  int vectors = 0, miscompares = 0, trig_cnt = 0;

  prog_loader #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .bus_own(bus_own), .core_reset_n(core_reset_n),
    .trigger_program(trigger_program), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr] ^ ((corrupt && mem_addr == 16'h0012) ? 8'hFF : 8'h00);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (trigger_program) trig_cnt++;
      if (mem_we) begin
        chk("we_needs_valid", {31'd0, s_valid}, 32'd1);
        if (sb_addr.size() == 0) chk("unexpected_write", {16'd0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, sb_addr.pop_front()});
          chk("wr_data", {24'd0, mem_din}, {24'd0, sb_data.pop_front()});
        end
      end
    end
  end

  task automatic load(input logic [15:0] base, input int len, input bit toggle, input int abort_at);
    int idx = 0, cyc = 0;
    bit hs;
    for (int i = 0; i < len; i++) begin
      sb_addr.push_back(base + 16'(i));
      sb_data.push_back(img[i]);
    end
    @(posedge clk); #1;
    base_addr = base; length = 16'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < len && cyc < 200 && idx != abort_at) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data = img[idx];
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    if (idx != abort_at) chk("load_beats", idx, len);
  endtask

  task automatic finish_load(input bit expect_err, input int trig0);
    int cyc = 0;
    while (!(done || err) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("end_timeout", {31'd0, cyc < 200}, 32'd1);
    chk("done", {31'd0, done}, {31'd0, !expect_err});
    chk("err", {31'd0, err}, {31'd0, expect_err});
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("bus_own_end", {31'd0, bus_own}, 32'd0);
    chk("core_reset_n_end", {31'd0, core_reset_n}, {31'd0, !expect_err});
    chk("trigger_pulses", trig_cnt - trig0, expect_err ? 0 : 1);
    chk("sb_empty", sb_addr.size(), 0);
  endtask

  task automatic set_img;
    img = '{8'hA9, 8'h04, 8'h85, 8'h02, 8'hA9, 8'h10, 8'hA9, 8'hFF,
            8'h85, 8'h0C, 8'hA9, 8'h03, 8'h85, 8'h04, 8'h85, 8'h06};
  endtask

  task automatic chk_mem16;
    for (int i = 0; i < 16; i++) chk("mem_image", {24'd0, mem[16'h0010 + 16'(i)]}, {24'd0, img[i]});
  endtask

  initial begin
    int t0;
    #3;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst_bus_own", {31'd0, bus_own}, 32'd0);
    chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
    chk("rst_trigger", {31'd0, trigger_program}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_flags", {29'd0, busy, done, err}, 32'd0);
    set_img();
    t0 = trig_cnt;
    load(16'h0010, 16, 1'b0, -1);
    finish_load(1'b0, t0);
    chk_mem16();
    t0 = trig_cnt;
    load(16'h0010, 16, 1'b1, -1);
    finish_load(1'b0, t0);
    chk_mem16();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    t0 = trig_cnt;
    load(16'hFFFE, 4, 1'b0, -1);
    finish_load(1'b0, t0);
    chk("wrap_fffe", {24'd0, mem[16'hFFFE]}, 32'h11);
    chk("wrap_ffff", {24'd0, mem[16'hFFFF]}, 32'h22);
    chk("wrap_0000", {24'd0, mem[16'h0000]}, 32'h33);
    chk("wrap_0001", {24'd0, mem[16'h0001]}, 32'h44);
    t0 = trig_cnt;
    load(16'h0100, 0, 1'b0, -1);
    finish_load(1'b0, t0);
    set_img();
    load(16'h0010, 16, 1'b0, 5);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
    chk("abort_flags", {28'd0, bus_own, busy, done, err}, 32'd0);
    chk("abort_pending", sb_addr.size(), 11);
    sb_addr.delete();
    sb_data.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    t0 = trig_cnt;
    load(16'h0010, 16, 1'b0, -1);
    finish_load(1'b0, t0);
    chk_mem16();
`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    t0 = trig_cnt;
    load(16'h0010, 16, 1'b0, -1);
    finish_load(1'b1, t0);
    corrupt = 1'b0;
    t0 = trig_cnt;
    load(16'h0010, 16, 1'b1, -1);
    finish_load(1'b0, t0);
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
